// File: rtl/mul16_seq_ctrl.sv
// Unsigned 16x16 -> 32-bit multiply sequenced over four passes of one shared
// 8x8 array multiplier, with valid/ready handshakes on both sides.

module mul_16 (
  input  logic [8:0]  a,
  input  logic [8:0]  b,
  output logic [17:0] s
);
  assign s = a * b;
endmodule

module mul16_seq_ctrl #(
  parameter bit MUL_REG = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] p,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DRAIN, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] a_q, b_q;
  logic [31:0] acc, acc_next;
  logic [31:0] pp_now, add_term;
  logic [1:0]  pass;
  logic [7:0]  mul_a, mul_b;
  logic [17:0] mul_s;
  logic [4:0]  shift;
  logic        accept;
  logic        unused_mul;

  assign accept = in_valid & in_ready;

  // pass[1] picks the a byte, pass[0] the b byte: 0=lo*lo, 1=lo*hi, 2=hi*lo, 3=hi*hi
  assign mul_a = pass[1] ? a_q[15:8] : a_q[7:0];
  assign mul_b = pass[0] ? b_q[15:8] : b_q[7:0];

  mul_16 u_mul (
    .a ({1'b0, mul_a}),
    .b ({1'b0, mul_b}),
    .s (mul_s)
  );

  // An 8x8 product never reaches the top two bits
  assign unused_mul = ^mul_s[17:16];

  always_comb begin
    case (pass)
      2'd0:    shift = 5'd0;
      2'd3:    shift = 5'd16;
      default: shift = 5'd8;
    endcase
  end

  assign pp_now = {16'h0000, mul_s[15:0]} << shift;

  generate
    if (MUL_REG) begin : g_pp_reg
      logic [31:0] pp_q;
      // Cleared on accept so the first MUL cycle accumulates zero
      always_ff @(posedge clk) begin
        if (rst || accept) pp_q <= '0;
        else if (state == MUL) pp_q <= pp_now;
      end
      assign add_term = pp_q;
    end else begin : g_pp_comb
      assign add_term = pp_now;
    end
  endgenerate

  assign acc_next = acc + add_term;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = MUL;
      MUL:     if (pass == 2'd3) state_next = MUL_REG ? DRAIN : DONE;
      DRAIN:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      pass <= '0;
      p    <= '0;
    end else begin
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        acc  <= '0;
        pass <= '0;
      end else if (state == MUL || state == DRAIN) begin
        acc <= acc_next;
        if (state == MUL) pass <= pass + 2'd1;
      end
      // p captures the final sum on the way into DONE and then holds
      if (state != DONE && state_next == DONE) p <= acc_next;
    end
  end

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Self-checking bench: runs MUL_REG=0 and MUL_REG=1 instances side by side on
// shared inputs, with a per-instance scoreboard of a*b products.

module tb_mul16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a, b;

  logic        in_ready0, out_valid0, busy0;
  logic [31:0] p0;
  logic        in_ready1, out_valid1, busy1;
  logic [31:0] p1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit          b2b = 1'b0;
  int          last0 = -1, last1 = -1;
  int          n_acc0 = 0;

  always #5 clk = ~clk;

  mul16_seq_ctrl #(.MUL_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .p(p0), .busy(busy0)
  );

  mul16_seq_ctrl #(.MUL_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .p(p1), .busy(busy1)
  );

  // Scoreboard monitor: inputs only change on negedges, so a sample just after
  // the negedge shows exactly what the next rising edge will see.
  always begin
    logic [31:0] prod, exp_p;
    @(negedge clk);
    #1;
    cyc++;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      prod = {16'h0000, a} * {16'h0000, b};
      if (in_valid && in_ready0) begin
        q0.push_back(prod);
        n_acc0++;
        if (b2b && last0 >= 0) begin
          checks++;
          if (cyc - last0 != 6) begin
            failures++;
            $display("FAIL b2b_interval0 got=%0d want=6", cyc - last0);
          end
        end
        last0 = cyc;
      end
      if (in_valid && in_ready1) begin
        q1.push_back(prod);
        if (b2b && last1 >= 0) begin
          checks++;
          if (cyc - last1 != 7) begin
            failures++;
            $display("FAIL b2b_interval1 got=%0d want=7", cyc - last1);
          end
        end
        last1 = cyc;
      end
      if (out_valid0 && out_ready) begin
        checks++;
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL sb0_unexpected p=%h want=<none>", p0);
        end else begin
          exp_p = q0.pop_front();
          if (p0 !== exp_p) begin
            failures++;
            $display("FAIL sb0_product p=%h want=%h", p0, exp_p);
          end
        end
      end
      if (out_valid1 && out_ready) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL sb1_unexpected p=%h want=<none>", p1);
        end else begin
          exp_p = q1.pop_front();
          if (p1 !== exp_p) begin
            failures++;
            $display("FAIL sb1_product p=%h want=%h", p1, exp_p);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Returns on a negedge where both instances are idle.
  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (in_ready0 && in_ready1) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_idle got=busy want=idle within %0d cycles", bound);
  endtask

  // One transaction with out_ready high; k counts cycles after the handshake cycle T.
  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tbv,
                         input logic [31:0] exp_p, input string nm);
    wait_idle(20);
    a = ta; b = tbv; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      checks += 6;
      if (out_valid0 !== 1'(k == 5)) begin
        failures++; $display("FAIL %s out_valid0 k=%0d got=%b want=%b", nm, k, out_valid0, k == 5);
      end
      if (busy0 !== 1'(k <= 5)) begin
        failures++; $display("FAIL %s busy0 k=%0d got=%b want=%b", nm, k, busy0, k <= 5);
      end
      if (in_ready0 !== 1'(k >= 6)) begin
        failures++; $display("FAIL %s in_ready0 k=%0d got=%b want=%b", nm, k, in_ready0, k >= 6);
      end
      if (out_valid1 !== 1'(k == 6)) begin
        failures++; $display("FAIL %s out_valid1 k=%0d got=%b want=%b", nm, k, out_valid1, k == 6);
      end
      if (busy1 !== 1'(k <= 6)) begin
        failures++; $display("FAIL %s busy1 k=%0d got=%b want=%b", nm, k, busy1, k <= 6);
      end
      if (in_ready1 !== 1'(k >= 7)) begin
        failures++; $display("FAIL %s in_ready1 k=%0d got=%b want=%b", nm, k, in_ready1, k >= 7);
      end
      if (k == 5) begin
        checks++;
        if (p0 !== exp_p) begin
          failures++; $display("FAIL %s p0 got=%h want=%h", nm, p0, exp_p);
        end
      end
      if (k == 6) begin
        checks++;
        if (p1 !== exp_p) begin
          failures++; $display("FAIL %s p1 got=%h want=%h", nm, p1, exp_p);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b%b want=00", in_ready0, in_ready1);
    end
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b%b want=00", out_valid0, out_valid1);
    end
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b%b want=00", busy0, busy1);
    end
    if (p0 !== 32'h0 || p1 !== 32'h0) begin
      failures++; $display("FAIL reset_p got=%h/%h want=0", p0, p1);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      failures++; $display("FAIL reset_release_in_ready got=%b%b want=11", in_ready0, in_ready1);
    end
  endtask

  task automatic test_basic();
    run_txn(16'h1234, 16'h5678, 32'h0626_0060, "basic");
  endtask

  task automatic test_corners();
    run_txn(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "max");
    run_txn(16'h0000, 16'hABCD, 32'h0000_0000, "zero");
    run_txn(16'h8001, 16'h8001, 32'h4001_0001, "msb");
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_p;
    exp_p = 32'h0003_0A08;  // 0x0102 * 0x0304
    wait_idle(20);
    a = 16'h0102; b = 16'h0304; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);  // k=1: a second pair stays offered the whole time
    a = 16'h1111; b = 16'h2222;
    repeat (3) @(negedge clk);  // k=2..4
    for (int k = 5; k <= 8; k++) begin
      @(negedge clk);
      checks += 4;
      if (out_valid0 !== 1'b1) begin
        failures++; $display("FAIL bp_out_valid0 k=%0d got=%b want=1", k, out_valid0);
      end
      if (p0 !== exp_p) begin
        failures++; $display("FAIL bp_p0 k=%0d got=%h want=%h", k, p0, exp_p);
      end
      if (in_ready0 !== 1'b0) begin
        failures++; $display("FAIL bp_in_ready0 k=%0d got=%b want=0", k, in_ready0);
      end
      if (in_ready1 !== 1'b0) begin
        failures++; $display("FAIL bp_in_ready1 k=%0d got=%b want=0", k, in_ready1);
      end
      if (k == 8) out_ready = 1'b1;
    end
    @(negedge clk);  // k=9: product drained, second pair now accepted
    checks += 3;
    if (out_valid0 !== 1'b0) begin
      failures++; $display("FAIL bp_drain_out_valid0 got=%b want=0", out_valid0);
    end
    if (in_ready0 !== 1'b1 || busy0 !== 1'b0) begin
      failures++; $display("FAIL bp_drain_idle0 got=ready%b busy%b want=ready1 busy0", in_ready0, busy0);
    end
    if (p0 !== exp_p) begin
      failures++; $display("FAIL bp_p0_retained got=%h want=%h", p0, exp_p);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(20);
  endtask

  task automatic test_reset_mid();
    wait_idle(20);
    a = 16'h00FF; b = 16'h0100; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);  // k=1
    in_valid = 1'b0;
    @(negedge clk);  // k=2
    @(negedge clk);  // k=3: pass 2
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      failures++; $display("FAIL midrst_busy got=%b%b want=00", busy0, busy1);
    end
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      failures++; $display("FAIL midrst_out_valid got=%b%b want=00", out_valid0, out_valid1);
    end
    if (p0 !== 32'h0 || p1 !== 32'h0) begin
      failures++; $display("FAIL midrst_p got=%h/%h want=0", p0, p1);
    end
    if (in_ready0 !== 1'b0) begin
      failures++; $display("FAIL midrst_in_ready_held got=%b want=0", in_ready0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      failures++; $display("FAIL midrst_release_in_ready got=%b%b want=11", in_ready0, in_ready1);
    end
    run_txn(16'h0003, 16'h0005, 32'h0000_000F, "after_rst");
  endtask

  task automatic test_back_to_back();
    wait_idle(20);
    b2b = 1'b1; last0 = -1; last1 = -1; n_acc0 = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 60 && n_acc0 < 4; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    checks++;
    if (n_acc0 != 4) begin
      failures++; $display("FAIL b2b_accepts got=%0d want=4", n_acc0);
    end
    wait_idle(30);
    repeat (2) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++; $display("FAIL b2b_leftover got=%0d/%0d want=0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
